reg_fifo_n: RTL and testbench
=============================

# reg_fifo_n

Parametrised multi-entry register FIFO for buffering operands ahead of the multiplier datapath. Depth and width are set by parameters. The block adds full/empty status, an occupancy count, error pulses and a registered output-valid strobe. It replaces single-entry operand registers wherever a producer can run ahead of the multiplier by more than one word.

## Interface
- DATA_SIZE, 8, word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- ADDR_SIZE, $clog2(DEPTH), derived; not to be overridden

- clk_i  input  1  clock; all state changes on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- load_i  input  1  write request; data_i is pushed if not full (or if simultaneous unload)
- data_i  input  DATA_SIZE  write data, sampled on accepted load
- unload_i  input  1  read request; oldest entry is popped to data_o if not empty
- data_o  output  DATA_SIZE  registered read data; holds its value until the next accepted unload
- valid_o  output  1  high for exactly the cycle after an accepted unload (data_o new)
- full_o  output  1  count == DEPTH
- empty_o  output  1  count == 0
- count_o  output  ADDR_SIZE+1  current occupancy, 0..DEPTH
- overflow_o  output  1  one-cycle pulse: load rejected because full
- underflow_o  output  1  one-cycle pulse: unload rejected because empty

## Operation
- Storage: DEPTH×DATA_SIZE register array, write pointer wr_ptr and read pointer rd_ptr (ADDR_SIZE bits, natural wrap DEPTH-1 → 0), occupancy counter cnt.
- Accept rules, evaluated on current state before the edge:
  - unload_acc = unload_i & ~empty
  - load_acc = load_i & (~full | unload_i)
- Accepted load: mem[wr_ptr] ← data_i; wr_ptr += 1.
- Accepted unload: data_o ← mem[rd_ptr]; rd_ptr += 1; valid_o ← 1.
- cnt update: +1 on load only, −1 on unload only, unchanged when both or neither.
- Full + load + unload: both accepted. Old oldest word goes to data_o; new word is written into the freed slot (wr_ptr == rd_ptr). Count stays DEPTH; no overflow.
- Empty + load + unload: unload rejected (underflow_o pulses), load accepted, count → 1. No fall-through.
- Full + load only: data dropped, array and pointers unchanged, overflow_o pulses.
- Empty + unload only: data_o holds, valid_o stays 0, underflow_o pulses.
- full_o, empty_o, count_o are combinational from cnt.
- Reset (rst_ni low, any time, including mid-burst): wr_ptr=0, rd_ptr=0, cnt=0, data_o=0, valid_o=0, overflow_o=0, underflow_o=0, so empty_o=1, full_o=0, count_o=0. The array is not reset; contents are don't-care. Requests during reset are ignored.

## Timing
- Write-to-read latency: a word loaded at edge N can be unloaded at edge N+1; it appears on data_o after edge N+1 with valid_o high in that cycle.
- Read latency: 1 cycle from accepted unload to data_o/valid_o.
- Status (count_o/full_o/empty_o) reflects all accepts at the edge, visible in the following cycle.
- overflow_o/underflow_o are registered: asserted in the cycle after the rejected request, for 1 cycle per rejected request.
- Back-to-back loads or unloads every cycle are supported; throughput is 1 word/cycle each direction.
- Reset release: first accepted request at the first rising edge with rst_ni high.

## Structure
- Shared package arith_fifo_pkg: default DATA_SIZE and DEPTH constants used by the multiplier-side FIFOs.
- One sub-module, fifo_ptr: ADDR_SIZE-bit wrapping counter with enable and async active-low reset, instantiated twice (write and read pointer). Array, counter and flags stay in reg_fifo_n.

## Test plan
- Reset mid-stream: load 0x11,0x22, assert rst_ni low mid-cycle → all outputs immediately 0 and empty_o=1; after release, unload → underflow_o pulse, data_o stays 0x00.
- Fill and drain, DEPTH=4: load 0xA1..0xA4 → full_o=1, count_o=4; unload ×4 → data_o 0xA1,0xA2,0xA3,0xA4 with valid_o each cycle, then empty_o=1.
- Overflow: full with 0xA1..0xA4, load 0xFF → overflow_o 1 cycle, count_o stays 4, later drain yields 0xA1..0xA4 (0xFF absent).
- Full simultaneous: full 0xA1..0xA4, load 0xB5 + unload same cycle → data_o=0xA1, count_o=4, no overflow; drain → 0xA2,0xA3,0xA4,0xB5.
- Empty simultaneous: empty, load 0x3C + unload → underflow_o pulse, valid_o=0, count_o=1; next unload → data_o=0x3C.
- Pointer wrap: 10 cycles of concurrent load/unload streaming 0x00..0x09 at occupancy 2 → output order preserved across wrap, count_o constant 2.

Source files
------------

// File: rtl/arith_fifo_pkg.sv
// Shared constants for the operand FIFOs feeding the multiplier datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
package arith_fifo_pkg;

    // Default operand width and buffer depth for multiplier-side FIFOs.
    localparam int ARITH_DATA_SIZE = 8;
    localparam int ARITH_DEPTH     = 4;

endpackage : arith_fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_SIZE-bit pointer with enable, used for FIFO read/write addressing.
// Latency: new value visible the cycle after en_i is sampled high.
// Backpressure: none; the caller gates en_i.
module fifo_ptr #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    localparam logic [W-1:0] LP_ONE = W'(1);

    logic [W-1:0] r_ptr;

    // Advance by one on enable; natural wrap from all-ones back to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (en_i) begin
            r_ptr <= r_ptr + LP_ONE;
        end
    end

    assign ptr_o = r_ptr;

endmodule : fifo_ptr

// File: rtl/reg_fifo_n.sv
// Multi-entry register FIFO buffering operands ahead of the multiplier.
// Latency: 1 cycle load-to-unloadable, 1 cycle unload-to-data_o/valid_o.
// Backpressure: loads rejected when full (unless unloading), unloads rejected when empty; rejects pulse overflow_o/underflow_o.
module reg_fifo_n
    import arith_fifo_pkg::*;
#(
    parameter  int DATA_SIZE = ARITH_DATA_SIZE,
    parameter  int DEPTH     = ARITH_DEPTH,
    localparam int ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 unload_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 valid_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [ADDR_SIZE:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam logic [ADDR_SIZE:0] LP_FULL = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] LP_ONE  = (ADDR_SIZE + 1)'(1);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_SIZE:0]   r_cnt;
    logic [DATA_SIZE-1:0] r_data;
    logic                 r_valid;
    logic                 r_ovf;
    logic                 r_unf;

    logic [ADDR_SIZE-1:0] w_wr_ptr;
    logic [ADDR_SIZE-1:0] w_rd_ptr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_load_acc;
    logic                 w_unload_acc;

    assign w_full  = (r_cnt == LP_FULL);
    assign w_empty = (r_cnt == '0);

    // A full FIFO still takes a load when the same edge frees a slot.
    assign w_unload_acc = unload_i & ~w_empty;
    assign w_load_acc   = load_i & (~w_full | unload_i);

    fifo_ptr #(.W(ADDR_SIZE)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_load_acc),
        .ptr_o  (w_wr_ptr)
    );

    fifo_ptr #(.W(ADDR_SIZE)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_unload_acc),
        .ptr_o  (w_rd_ptr)
    );

    // Storage array; not reset, contents are only meaningful once written.
    always_ff @(posedge clk_i) begin
        if (w_load_acc) begin
            r_mem[w_wr_ptr] <= data_i;
        end
    end

    // Occupancy: simultaneous accepted load and unload cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_load_acc && !w_unload_acc) begin
            r_cnt <= r_cnt + LP_ONE;
        end else if (w_unload_acc && !w_load_acc) begin
            r_cnt <= r_cnt - LP_ONE;
        end
    end

    // Registered read port, valid strobe and reject pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_unload_acc) begin
                r_data <= r_mem[w_rd_ptr];
            end
            r_valid <= w_unload_acc;
            r_ovf   <= load_i & ~w_load_acc;
            r_unf   <= unload_i & w_empty;
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign count_o     = r_cnt;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;

endmodule : reg_fifo_n

// File: tb/tb_reg_fifo_n.sv
// Directed bench for reg_fifo_n (DATA_SIZE=8, DEPTH=4).
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: exercises overflow, underflow and simultaneous full/empty cases.
module tb_reg_fifo_n;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AW = 2;

    logic          clk_i    = 1'b0;
    logic          rst_ni   = 1'b0;
    logic          load_i   = 1'b0;
    logic [DW-1:0] data_i   = '0;
    logic          unload_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          full_o;
    logic          empty_o;
    logic [AW:0]   count_o;
    logic          overflow_o;
    logic          underflow_o;

    int n_chk  = 0;
    int n_fail = 0;

    reg_fifo_n #(.DATA_SIZE(DW), .DEPTH(DP)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load_i),
        .data_i      (data_i),
        .unload_i    (unload_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          ld;
        logic [DW-1:0] d;
        logic          ul;
        logic [DW-1:0] ed;
        logic          ev;
        logic [AW:0]   ec;
        logic          eo;
        logic          eu;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ld, input logic [DW-1:0] d, input logic ul,
                                input logic [DW-1:0] ed, input logic ev, input int ec,
                                input logic eo, input logic eu);
        vec_t v;
        v.ld = ld; v.d = d; v.ul = ul;
        v.ed = ed; v.ev = ev; v.ec = (AW+1)'(ec); v.eo = eo; v.eu = eu;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] ed, input logic ev,
                             input int ec, input logic eo, input logic eu);
        chk({tag, " data_o"},      32'(data_o),      32'(ed));
        chk({tag, " valid_o"},     32'(valid_o),     32'(ev));
        chk({tag, " count_o"},     32'(count_o),     32'(ec));
        chk({tag, " full_o"},      32'(full_o),      32'(ec == DP));
        chk({tag, " empty_o"},     32'(empty_o),     32'(ec == 0));
        chk({tag, " overflow_o"},  32'(overflow_o),  32'(eo));
        chk({tag, " underflow_o"}, 32'(underflow_o), 32'(eu));
    endtask

    task automatic step(input logic ld, input logic [DW-1:0] d, input logic ul);
        load_i   = ld;
        data_i   = d;
        unload_i = ul;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Fill and drain.
        add(1, 8'hA1, 0, 8'h00, 0, 1, 0, 0);
        add(1, 8'hA2, 0, 8'h00, 0, 2, 0, 0);
        add(1, 8'hA3, 0, 8'h00, 0, 3, 0, 0);
        add(1, 8'hA4, 0, 8'h00, 0, 4, 0, 0);
        add(0, 8'h00, 1, 8'hA1, 1, 3, 0, 0);
        add(0, 8'h00, 1, 8'hA2, 1, 2, 0, 0);
        add(0, 8'h00, 1, 8'hA3, 1, 1, 0, 0);
        add(0, 8'h00, 1, 8'hA4, 1, 0, 0, 0);
        // Overflow: 0xFF dropped.
        add(1, 8'hA1, 0, 8'hA4, 0, 1, 0, 0);
        add(1, 8'hA2, 0, 8'hA4, 0, 2, 0, 0);
        add(1, 8'hA3, 0, 8'hA4, 0, 3, 0, 0);
        add(1, 8'hA4, 0, 8'hA4, 0, 4, 0, 0);
        add(1, 8'hFF, 0, 8'hA4, 0, 4, 1, 0);
        add(0, 8'h00, 0, 8'hA4, 0, 4, 0, 0);
        add(0, 8'h00, 1, 8'hA1, 1, 3, 0, 0);
        add(0, 8'h00, 1, 8'hA2, 1, 2, 0, 0);
        add(0, 8'h00, 1, 8'hA3, 1, 1, 0, 0);
        add(0, 8'h00, 1, 8'hA4, 1, 0, 0, 0);
        add(0, 8'h00, 1, 8'hA4, 0, 0, 0, 1);
        // Full with simultaneous load/unload.
        add(1, 8'hA1, 0, 8'hA4, 0, 1, 0, 0);
        add(1, 8'hA2, 0, 8'hA4, 0, 2, 0, 0);
        add(1, 8'hA3, 0, 8'hA4, 0, 3, 0, 0);
        add(1, 8'hA4, 0, 8'hA4, 0, 4, 0, 0);
        add(1, 8'hB5, 1, 8'hA1, 1, 4, 0, 0);
        add(0, 8'h00, 1, 8'hA2, 1, 3, 0, 0);
        add(0, 8'h00, 1, 8'hA3, 1, 2, 0, 0);
        add(0, 8'h00, 1, 8'hA4, 1, 1, 0, 0);
        add(0, 8'h00, 1, 8'hB5, 1, 0, 0, 0);
        // Empty with simultaneous load/unload: no fall-through.
        add(1, 8'h3C, 1, 8'hB5, 0, 1, 0, 1);
        add(0, 8'h00, 1, 8'h3C, 1, 0, 0, 0);
        // Pointer wrap: stream at occupancy 2.
        add(1, 8'h00, 0, 8'h3C, 0, 1, 0, 0);
        add(1, 8'h01, 0, 8'h3C, 0, 2, 0, 0);
        for (int k = 0; k < 10; k++) begin
            add(1, 8'(k + 2), 1, 8'(k), 1, 2, 0, 0);
        end
        add(0, 8'h00, 1, 8'h0A, 1, 1, 0, 0);
        add(0, 8'h00, 1, 8'h0B, 1, 0, 0, 0);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset", 8'h00, 0, 0, 0, 0);

        // ---------------- reset mid-stream ----------------
        rst_ni = 1'b1;
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        check_all("pre_rst_load", 8'h00, 0, 2, 0, 0);
        step(0, 8'h00, 1);
        check_all("pre_rst_unload", 8'h11, 1, 1, 0, 0);
        #3;
        rst_ni   = 1'b0;
        load_i   = 1'b1;
        unload_i = 1'b1;
        data_i   = 8'h33;
        #1;
        check_all("mid_rst", 8'h00, 0, 0, 0, 0);
        @(posedge clk_i);
        #1;
        check_all("req_in_rst", 8'h00, 0, 0, 0, 0);
        load_i   = 1'b0;
        unload_i = 1'b0;
        rst_ni   = 1'b1;
        step(0, 8'h00, 1);
        check_all("post_rst_unf", 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0);
        check_all("post_rst_idle", 8'h00, 0, 0, 0, 0);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].d, vecs[i].ul);
            check_all($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ev,
                      int'(vecs[i].ec), vecs[i].eo, vecs[i].eu);
        end

        // Reject pulses last exactly one cycle per rejected request.
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        check_all("unf_b2b", 8'h0B, 0, 0, 0, 1);
        step(0, 8'h00, 0);
        check_all("unf_clear", 8'h0B, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_reg_fifo_n
